// File: rtl/pc_sequencer.sv
// PC sequencer: fetch address, ID-stage PC, pipeline enables and clears.
// Optional cycle counter output cyc_cnt enabled by macro PC_CYCLE_COUNT_EN.
module pc_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        halt,
    input  logic        if_flush,
    input  logic        id_flush,
    input  logic        ex_flush,
    input  logic        pc_op,
    input  logic        b_jmp,
    input  logic        overflow_error_warning,
    input  logic        stall,
    input  logic [7:0]  br_off,
    input  logic [11:0] jmp_off,
    output logic [15:0] pc,
    output logic [15:0] id_pc,
    output logic        if_id_en,
    output logic        if_id_clr,
    output logic        id_ex_clr,
    output logic        ex_mem_clr,
    output logic        halted,
    output logic        fault
`ifdef PC_CYCLE_COUNT_EN
    ,
    output logic [15:0] cyc_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2,
        FAULT  = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] pc_d;
    logic [15:0] id_pc_d;
    logic [1:0]  drain_q;
    logic [1:0]  drain_d;
    logic [15:0] br_tgt;
    logic [15:0] jmp_tgt;

    assign br_tgt  = id_pc + 16'd2 + {{7{br_off[7]}}, br_off, 1'b0};
    assign jmp_tgt = {id_pc[15:13], jmp_off, 1'b0};

    // State, PC and drain counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            pc      <= 16'h0000;
            id_pc   <= 16'h0000;
            drain_q <= 2'd0;
        end else begin
            state_q <= state_d;
            pc      <= pc_d;
            id_pc   <= id_pc_d;
            drain_q <= drain_d;
        end
    end

    // Next state and next PC. HALTED and FAULT are sticky until reset.
    always_comb begin
        state_d = state_q;
        pc_d    = pc;
        id_pc_d = id_pc;
        drain_d = drain_q;
        unique case (state_q)
            RUN: begin
                if (overflow_error_warning) begin
                    state_d = FAULT;
                end else if (halt) begin
                    state_d = DRAIN;
                    drain_d = 2'd0;
                end else if (pc_op) begin
                    pc_d = b_jmp ? br_tgt : jmp_tgt;
                end else if (!stall) begin
                    pc_d    = pc + 16'd2;
                    id_pc_d = pc;
                end
            end
            DRAIN: begin
                if (overflow_error_warning) begin
                    state_d = FAULT;
                end else if (drain_q == 2'd2) begin
                    state_d = HALTED;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            default: begin
            end
        endcase
    end

    // Pipeline enables and clears; everything is cleared in reset or on overflow.
    always_comb begin
        if_id_en   = 1'b0;
        if_id_clr  = 1'b1;
        id_ex_clr  = 1'b1;
        ex_mem_clr = 1'b1;
        if (reset && !overflow_error_warning) begin
            unique case (state_q)
                RUN: begin
                    if_id_en   = !halt && (pc_op || !stall);
                    if_id_clr  = halt || pc_op || if_flush;
                    id_ex_clr  = id_flush || stall;
                    ex_mem_clr = ex_flush;
                end
                DRAIN: begin
                    if_id_en   = 1'b0;
                    if_id_clr  = 1'b1;
                    id_ex_clr  = id_flush;
                    ex_mem_clr = ex_flush;
                end
                default: begin
                end
            endcase
        end
    end

    // Status flags decoded from the state register.
    always_comb begin
        halted = (state_q == HALTED);
        fault  = (state_q == FAULT);
    end

`ifdef PC_CYCLE_COUNT_EN
    // Saturating count of edges spent in RUN or DRAIN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_cnt <= 16'h0000;
        end else if ((state_q == RUN || state_q == DRAIN) &&
                     cyc_cnt != 16'hFFFF) begin
            cyc_cnt <= cyc_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed steps plus randomized run,
// all checked against a behavioural model of the sequencer.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        halt;
    logic        if_flush;
    logic        id_flush;
    logic        ex_flush;
    logic        pc_op;
    logic        b_jmp;
    logic        overflow_error_warning;
    logic        stall;
    logic [7:0]  br_off;
    logic [11:0] jmp_off;
    logic [15:0] pc;
    logic [15:0] id_pc;
    logic        if_id_en;
    logic        if_id_clr;
    logic        id_ex_clr;
    logic        ex_mem_clr;
    logic        halted;
    logic        fault;
`ifdef PC_CYCLE_COUNT_EN
    logic [15:0] cyc_cnt;
`endif

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk                    (clk),
        .reset                  (reset),
        .halt                   (halt),
        .if_flush               (if_flush),
        .id_flush               (id_flush),
        .ex_flush               (ex_flush),
        .pc_op                  (pc_op),
        .b_jmp                  (b_jmp),
        .overflow_error_warning (overflow_error_warning),
        .stall                  (stall),
        .br_off                 (br_off),
        .jmp_off                (jmp_off),
        .pc                     (pc),
        .id_pc                  (id_pc),
        .if_id_en               (if_id_en),
        .if_id_clr              (if_id_clr),
        .id_ex_clr              (id_ex_clr),
        .ex_mem_clr             (ex_mem_clr),
        .halted                 (halted),
        .fault                  (fault)
`ifdef PC_CYCLE_COUNT_EN
        ,
        .cyc_cnt                (cyc_cnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode 0 run, 1 drain, 2 halted, 3 fault.
    int          m_mode;
    int          m_left;
    logic [15:0] m_pc;
    logic [15:0] m_id;
    logic [15:0] m_cyc;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        halt = 1'b0;
        if_flush = 1'b0;
        id_flush = 1'b0;
        ex_flush = 1'b0;
        pc_op = 1'b0;
        b_jmp = 1'b0;
        overflow_error_warning = 1'b0;
        stall = 1'b0;
        br_off = 8'h00;
        jmp_off = 12'h000;
    endtask

    task automatic m_reset();
        m_mode = 0;
        m_left = 0;
        m_pc = 16'h0000;
        m_id = 16'h0000;
        m_cyc = 16'h0000;
    endtask

    // Compare every output against what the model expects right now.
    task automatic check_now();
        logic en, ic, dc, ec;
        if (!reset || overflow_error_warning || m_mode >= 2) begin
            en = 1'b0; ic = 1'b1; dc = 1'b1; ec = 1'b1;
        end else if (m_mode == 1) begin
            en = 1'b0; ic = 1'b1; dc = id_flush; ec = ex_flush;
        end else if (halt) begin
            en = 1'b0; ic = 1'b1; dc = id_flush | stall; ec = ex_flush;
        end else begin
            en = pc_op | ~stall;
            ic = if_flush | pc_op;
            dc = id_flush | stall;
            ec = ex_flush;
        end
        chk("pc", pc, m_pc);
        chk("id_pc", id_pc, m_id);
        chk("if_id_en", 16'(if_id_en), 16'(en));
        chk("if_id_clr", 16'(if_id_clr), 16'(ic));
        chk("id_ex_clr", 16'(id_ex_clr), 16'(dc));
        chk("ex_mem_clr", 16'(ex_mem_clr), 16'(ec));
        chk("halted", 16'(halted), 16'(m_mode == 2));
        chk("fault", 16'(fault), 16'(m_mode == 3));
`ifdef PC_CYCLE_COUNT_EN
        chk("cyc_cnt", cyc_cnt, m_cyc);
`endif
    endtask

    // Advance the model across one rising edge.
    task automatic advance();
        if (!reset) return;
        if (m_mode <= 1 && m_cyc != 16'hFFFF) m_cyc = m_cyc + 16'd1;
        if (m_mode == 0) begin
            if (overflow_error_warning) m_mode = 3;
            else if (halt) begin
                m_mode = 1;
                m_left = 3;
            end else if (pc_op) begin
                if (b_jmp)
                    m_pc = 16'(int'(m_id) + 2 + 2 * int'($signed(br_off)));
                else
                    m_pc = (m_id & 16'hE000) | 16'(int'(jmp_off) * 2);
            end else if (!stall) begin
                m_id = m_pc;
                m_pc = m_pc + 16'd2;
            end
        end else if (m_mode == 1) begin
            if (overflow_error_warning) m_mode = 3;
            else begin
                m_left--;
                if (m_left == 0) m_mode = 2;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_now();
        @(posedge clk);
        advance();
        #1;
    endtask

    initial begin
        clr_in();
        reset = 1'b0;
        m_reset();
        #1;
        chk("rst_en", 16'(if_id_en), 16'd0);
        chk("rst_clr", 16'(if_id_clr & id_ex_clr & ex_mem_clr), 16'd1);
        tick();
        tick();
        reset = 1'b1;

        // Sequential fetch from address 0.
        for (int i = 0; i < 4; i++) begin
            chk("seq_pc", pc, 16'(2 * i));
            tick();
        end
        chk("seq_pc", pc, 16'h0008);
        chk("seq_id", id_pc, 16'h0006);
        repeat (5) tick();
        chk("pre_br_id", id_pc, 16'h0010);

        // Backward branch.
        pc_op = 1'b1; b_jmp = 1'b1; br_off = 8'hFE;
        #1;
        chk("br_clr", 16'(if_id_clr), 16'd1);
        tick();
        clr_in();
        chk("br_pc", pc, 16'h000E);
        repeat (9) tick();
        chk("pre_stall", pc, 16'h0020);

        // Two stall cycles.
        stall = 1'b1;
        repeat (2) begin
            #1;
            chk("stall_en", 16'(if_id_en), 16'd0);
            chk("stall_dc", 16'(id_ex_clr), 16'd1);
            tick();
            chk("stall_pc", pc, 16'h0020);
        end
        stall = 1'b0;
        tick();
        chk("post_stall", pc, 16'h0022);

        // Jump to 0, then hop forward with branches until id_pc = 0xA000.
        pc_op = 1'b1; jmp_off = 12'h000;
        tick();
        clr_in();
        tick();
        for (int k = 0; k < 160; k++) begin
            pc_op = 1'b1; b_jmp = 1'b1; br_off = 8'h7F;
            tick();
            clr_in();
            tick();
        end
        chk("hop_id", id_pc, 16'hA000);
        pc_op = 1'b1; jmp_off = 12'h123;
        tick();
        clr_in();
        chk("jmp_pc", pc, 16'hA246);

        // Reach 0xFFFE and wrap.
        tick();
        for (int k = 0; k < 200 && m_id < 16'hFF00; k++) begin
            pc_op = 1'b1; b_jmp = 1'b1; br_off = 8'h7F;
            tick();
            clr_in();
            tick();
        end
        pc_op = 1'b1; b_jmp = 1'b1;
        br_off = 8'((16'hFFFE - m_id - 16'd2) >> 1);
        tick();
        clr_in();
        chk("top_pc", pc, 16'hFFFE);
        tick();
        chk("wrap_pc", pc, 16'h0000);
        chk("wrap_id", id_pc, 16'hFFFE);
        repeat (24) tick();
        chk("pre_halt", pc, 16'h0030);

        // Halt, drain with ignored redirects, then halted.
        halt = 1'b1;
        #1;
        chk("halt_clr", 16'(if_id_clr), 16'd1);
        tick();
        halt = 1'b0;
        pc_op = 1'b1; b_jmp = 1'b1; br_off = 8'h10;
        repeat (3) begin
            chk("drain_halted", 16'(halted), 16'd0);
            tick();
            chk("drain_pc", pc, 16'h0030);
        end
        chk("halted", 16'(halted), 16'd1);
        clr_in();
        repeat (2) tick();
        chk("halted_hold", 16'(halted), 16'd1);

        // Overflow during drain, then reset mid-fault.
        reset = 1'b0;
        m_reset();
        #1;
        chk("rst_halted", 16'(halted), 16'd0);
        tick();
        reset = 1'b1;
        repeat (3) tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        tick();
        overflow_error_warning = 1'b1;
        #1;
        chk("ovf_clr", 16'(if_id_clr & id_ex_clr & ex_mem_clr), 16'd1);
        tick();
        overflow_error_warning = 1'b0;
        chk("fault", 16'(fault), 16'd1);
        chk("fault_halted", 16'(halted), 16'd0);
        chk("fault_pc", pc, 16'h0006);
        repeat (2) tick();
        #2;
        reset = 1'b0;
        m_reset();
        #1;
        chk("rst_fault_pc", pc, 16'h0000);
        chk("rst_fault", 16'(fault), 16'd0);
        tick();
        reset = 1'b1;

        // Randomized run.
        for (int n = 0; n < 3000; n++) begin
            if_flush = 1'($urandom_range(0, 1));
            id_flush = 1'($urandom_range(0, 1));
            ex_flush = 1'($urandom_range(0, 1));
            pc_op = ($urandom_range(0, 3) == 0);
            b_jmp = 1'($urandom_range(0, 1));
            stall = ($urandom_range(0, 3) == 0);
            halt = ($urandom_range(0, 40) == 0);
            overflow_error_warning = ($urandom_range(0, 80) == 0);
            br_off = 8'($urandom);
            jmp_off = 12'($urandom);
            if ($urandom_range(0, 120) == 0) begin
                reset = 1'b0;
                m_reset();
            end else begin
                reset = 1'b1;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
